// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg
// Shared types and constants for the two-master AHB-lite arbiter:
//   port_st_e  - per-master port state (IDLE / PEND / DATA)
//   HTRANS_*   - transfer-type encodings
//   HBURST_*   - burst encodings (only SINGLE is ever issued)
//   ahb_ctl_t  - control part of a port's hold register (address held alongside)
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing held, master sees HREADY=1
        ST_PEND = 2'd1,   // address held, waiting for the shared slave
        ST_DATA = 2'd2    // issued, slave data phase in progress
    } port_st_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic       hwrite;
        logic [2:0] hsize;
        logic [3:0] hprot;
    } ahb_ctl_t;

endpackage

// File: rtl/ahb_dual_arb_if.sv
// ahb_dual_arb_if
// Bundles the upstream master-side signals (m_*) and the shared downstream
// slave port (s_*) of the dual-master arbiter.
//   modport master : the arbiter's view (it masters the shared slave and
//                    answers the upstream masters)
//   modport slave  : the environment's view (upstream masters + shared slave)
interface ahb_dual_arb_if #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 64
);
    // upstream masters
    logic [NM-1:0][AW-1:0] m_HADDR;
    logic [NM-1:0][1:0]    m_HTRANS;
    logic [NM-1:0]         m_HWRITE;
    logic [NM-1:0][2:0]    m_HSIZE;
    logic [NM-1:0][2:0]    m_HBURST;
    logic [NM-1:0][3:0]    m_HPROT;
    logic [NM-1:0][DW-1:0] m_HWDATA;
    logic [NM-1:0]         m_HREADY;
    logic [NM-1:0]         m_HRESP;
    logic [NM-1:0][DW-1:0] m_HRDATA;

    // shared slave
    logic          s_HSEL;
    logic [AW-1:0] s_HADDR;
    logic [1:0]    s_HTRANS;
    logic          s_HWRITE;
    logic [2:0]    s_HSIZE;
    logic [2:0]    s_HBURST;
    logic [3:0]    s_HPROT;
    logic [DW-1:0] s_HWDATA;
    logic          s_HREADY;
    logic          s_HREADYOUT;
    logic          s_HRESP;
    logic [DW-1:0] s_HRDATA;

    modport master (
        input  m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HBURST, m_HPROT, m_HWDATA,
        output m_HREADY, m_HRESP, m_HRDATA,
        output s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT,
               s_HWDATA, s_HREADY,
        input  s_HREADYOUT, s_HRESP, s_HRDATA
    );

    modport slave (
        output m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HBURST, m_HPROT, m_HWDATA,
        input  m_HREADY, m_HRESP, m_HRDATA,
        input  s_HSEL, s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT,
               s_HWDATA, s_HREADY,
        output s_HREADYOUT, s_HRESP, s_HRDATA
    );

endinterface

// File: rtl/ahb_arb_port.sv
// ahb_arb_port
// One upstream master port: IDLE/PEND/DATA state machine plus the hold
// register that keeps the accepted address phase until the arbiter issues it.
//   HCLK, HRESETn   - clock, async active-low reset
//   req             - master HTRANS[1] (NONSEQ/SEQ); BUSY/IDLE are ignored
//   haddr..hprot    - master address-phase signals, captured on acceptance
//   grant           - arbiter issues this port's held transfer this cycle
//   s_hreadyout     - shared slave ready (completes this port's data phase)
//   state, hready   - current state and HREADY returned to the master
//   hold_addr/ctl   - held address phase
module ahb_arb_port
    import ahb_arb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          req,
    input  logic [AW-1:0] haddr,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [3:0]    hprot,
    input  logic          grant,
    input  logic          s_hreadyout,
    output port_st_e      state,
    output logic          hready,
    output logic [AW-1:0] hold_addr,
    output ahb_ctl_t      hold_ctl
);

    port_st_e state_q, state_d;
    logic     capture;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            hold_addr <= '0;
            hold_ctl  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_addr <= haddr;
                hold_ctl  <= '{hwrite: hwrite, hsize: hsize, hprot: hprot};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hready  = 1'b1;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    state_d = ST_PEND;
                end
            end
            // Stalling the master here keeps its HWDATA stable until the
            // slave data phase actually happens.
            ST_PEND: begin
                hready = 1'b0;
                if (grant) state_d = ST_DATA;
            end
            // Completion and the next address acceptance share one edge.
            ST_DATA: begin
                hready = s_hreadyout;
                if (s_hreadyout) begin
                    if (req) begin
                        capture = 1'b1;
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/ahb_dual_arb.sv
// ahb_dual_arb
// Two AHB-lite masters sharing one AHB-lite slave. Each master port holds its
// accepted address phase; whenever the slave is ready, one pending port is
// issued as a NONSEQ SINGLE, chosen round-robin.
//   HCLK, HRESETn - clock, async active-low reset
//   bus           - ahb_dual_arb_if.master: m_* upstream masters, s_* slave
module ahb_dual_arb
    import ahb_arb_pkg::*;
#(
    parameter int NM = 2,   // only 2 supported
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_dual_arb_if.master bus
);

    port_st_e              st [NM];
    logic [NM-1:0]         pend;
    logic [NM-1:0]         grant;
    logic [NM-1:0]         hready;
    logic [NM-1:0][AW-1:0] hold_addr;
    ahb_ctl_t [NM-1:0]     hold_ctl;

    logic last_q;    // port issued most recently
    logic owner_q;   // port owning the current slave data phase
    logic issue;
    logic win;
    logic sel;
    logic unused_in;

    for (genvar i = 0; i < NM; i++) begin : g_port
        ahb_arb_port #(.AW(AW)) u_port (
            .HCLK        (HCLK),
            .HRESETn     (HRESETn),
            .req         (bus.m_HTRANS[i][1]),
            .haddr       (bus.m_HADDR[i]),
            .hwrite      (bus.m_HWRITE[i]),
            .hsize       (bus.m_HSIZE[i]),
            .hprot       (bus.m_HPROT[i]),
            .grant       (grant[i]),
            .s_hreadyout (bus.s_HREADYOUT),
            .state       (st[i]),
            .hready      (hready[i]),
            .hold_addr   (hold_addr[i]),
            .hold_ctl    (hold_ctl[i])
        );

        assign pend[i]         = (st[i] == ST_PEND);
        assign grant[i]        = issue && (int'(win) == i);
        assign bus.m_HREADY[i] = hready[i];
        assign bus.m_HRESP[i]  = (st[i] == ST_DATA) && bus.s_HRESP;
        assign bus.m_HRDATA[i] = bus.s_HRDATA;
    end

    // Issuing only while the slave is ready means a new data phase always
    // starts exactly as the previous owner's completes.
    assign issue = bus.s_HREADYOUT && (|pend);

    always_comb begin
        if (pend[0] && pend[1]) win = ~last_q;
        else                    win = pend[1];
    end

    // With no issue the address mux stays on the last issued port.
    assign sel = issue ? win : last_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_q  <= 1'b1;   // port 0 wins the first contention
            owner_q <= 1'b0;
        end else if (issue) begin
            last_q  <= win;
            owner_q <= win;
        end
    end

    assign bus.s_HSEL   = issue;
    assign bus.s_HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.s_HADDR  = hold_addr[sel];
    assign bus.s_HWRITE = hold_ctl[sel].hwrite;
    assign bus.s_HSIZE  = hold_ctl[sel].hsize;
    assign bus.s_HPROT  = hold_ctl[sel].hprot;
    assign bus.s_HBURST = HBURST_SINGLE;
    assign bus.s_HWDATA = bus.m_HWDATA[owner_q];
    assign bus.s_HREADY = bus.s_HREADYOUT;

    // Bursts are split into singles and HTRANS[0] never matters.
    assign unused_in = ^{bus.m_HBURST, bus.m_HTRANS[0][0], bus.m_HTRANS[1][0]};

endmodule

// File: tb/tb_ahb_dual_arb.sv
`timescale 1ns/1ps
module tb_ahb_dual_arb;
    import ahb_arb_pkg::*;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 64;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    ahb_dual_arb_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

    ahb_dual_arb #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_HADDR     = '0;
        bus.m_HTRANS    = '0;
        bus.m_HWRITE    = '0;
        bus.m_HSIZE     = '0;
        bus.m_HBURST    = '0;
        bus.m_HPROT     = '0;
        bus.m_HWDATA    = '0;
        bus.s_HREADYOUT = 1'b1;
        bus.s_HRESP     = 1'b0;
        bus.s_HRDATA    = 64'h0123_4567_89AB_CDEF;
    endtask

    // Ends at posedge+1 with reset released: that cycle is "cycle 0".
    task automatic do_reset();
        idle_inputs();
        HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  tr0;
        logic [1:0]  tr1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        rdy;
        logic [1:0]  exp_tr;
        logic [31:0] exp_addr;
        logic [1:0]  exp_mrdy;
    } vec_t;

    vec_t tbl [11];

    // random-test model state
    logic        pend [2];
    logic [31:0] s_addr [2];
    logic        s_wr [2];
    logic [2:0]  s_sz [2];
    logic [63:0] s_wd [2];
    logic        own_v;
    int          own_p;
    logic [63:0] own_wd;
    int          last_p;
    logic [1:0]  cur_tr [2];
    logic        mr_prev [2];
    logic        exp_mr [2];
    logic        acc [2];
    int          n_iss;

    initial begin
        HRESETn = 1'b0;
        idle_inputs();

        // ---------------- reset state ----------------
        tick();
        @(negedge HCLK);
        chk("rst_mready",  bus.m_HREADY, 2'b11);
        chk("rst_mresp",   bus.m_HRESP,  2'b00);
        chk("rst_strans",  bus.s_HTRANS, HTRANS_IDLE);
        chk("rst_ssel",    bus.s_HSEL,   1'b0);
        chk("rst_saddr",   bus.s_HADDR,  32'h0);
        chk("rst_sburst",  bus.s_HBURST, 3'b000);

        // ---------------- table-driven sequence ----------------
        tbl[0]  = '{2'b10, 2'b00, 32'h1000, 32'h0,    1'b1, 2'b00, 32'h0,    2'b11};
        tbl[1]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 2'b10, 32'h1000, 2'b10};
        tbl[2]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 2'b00, 32'h1000, 2'b11};
        tbl[3]  = '{2'b10, 2'b10, 32'h2000, 32'h3000, 1'b1, 2'b00, 32'h1000, 2'b11};
        tbl[4]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 2'b10, 32'h3000, 2'b00};
        tbl[5]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 2'b10, 32'h2000, 2'b10};
        tbl[6]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 2'b00, 32'h2000, 2'b11};
        tbl[7]  = '{2'b10, 2'b00, 32'h4000, 32'h0,    1'b0, 2'b00, 32'h2000, 2'b11};
        tbl[8]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b0, 2'b00, 32'h4000, 2'b10};
        tbl[9]  = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 2'b10, 32'h4000, 2'b10};
        tbl[10] = '{2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 2'b00, 32'h4000, 2'b11};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.m_HTRANS[0] = tbl[i].tr0;
            bus.m_HTRANS[1] = tbl[i].tr1;
            bus.m_HADDR[0]  = tbl[i].a0;
            bus.m_HADDR[1]  = tbl[i].a1;
            bus.s_HREADYOUT = tbl[i].rdy;
            @(negedge HCLK);
            chk($sformatf("tbl%0d_strans", i), bus.s_HTRANS, tbl[i].exp_tr);
            chk($sformatf("tbl%0d_ssel", i),   bus.s_HSEL,   tbl[i].exp_tr[1]);
            chk($sformatf("tbl%0d_saddr", i),  bus.s_HADDR,  tbl[i].exp_addr);
            chk($sformatf("tbl%0d_mready", i), bus.m_HREADY, tbl[i].exp_mrdy);
            if (i == 2) chk("tbl2_rdata0", bus.m_HRDATA[0], 64'h0123_4567_89AB_CDEF);
            tick();
        end

        // ---------------- both NONSEQ right after reset ----------------
        do_reset();
        bus.m_HTRANS[0] = HTRANS_NONSEQ; bus.m_HADDR[0] = 32'hA000;
        bus.m_HTRANS[1] = HTRANS_SEQ;    bus.m_HADDR[1] = 32'hB000;
        tick();
        bus.m_HTRANS = '0;
        @(negedge HCLK);
        chk("both_c1_addr",  bus.s_HADDR,  32'hA000);
        chk("both_c1_trans", bus.s_HTRANS, HTRANS_NONSEQ);
        tick();
        @(negedge HCLK);
        chk("both_c2_addr",  bus.s_HADDR,     32'hB000);
        chk("both_c2_trans", bus.s_HTRANS,    HTRANS_NONSEQ);
        chk("both_c2_rdy0",  bus.m_HREADY[0], 1'b1);
        chk("both_c2_rdy1",  bus.m_HREADY[1], 1'b0);
        tick();
        @(negedge HCLK);
        chk("both_c3_rdy1",  bus.m_HREADY[1], 1'b1);
        chk("both_c3_trans", bus.s_HTRANS,    HTRANS_IDLE);

        // ---------------- slave wait states ----------------
        do_reset();
        bus.m_HTRANS[0] = HTRANS_NONSEQ; bus.m_HADDR[0] = 32'h100; bus.m_HWRITE[0] = 1'b1;
        tick();
        bus.m_HTRANS[0] = HTRANS_IDLE;
        bus.m_HWDATA[0] = 64'hAAAA_5555_1234_0001;
        bus.m_HTRANS[1] = HTRANS_NONSEQ; bus.m_HADDR[1] = 32'h200;
        @(negedge HCLK);
        chk("wait_issue0", bus.s_HADDR, 32'h100);
        tick();
        bus.m_HTRANS[1] = HTRANS_IDLE;
        for (int w = 0; w < 3; w++) begin
            bus.s_HREADYOUT = 1'b0;
            @(negedge HCLK);
            chk($sformatf("wait%0d_trans", w), bus.s_HTRANS,    HTRANS_IDLE);
            chk($sformatf("wait%0d_rdy0", w),  bus.m_HREADY[0], 1'b0);
            chk($sformatf("wait%0d_wdata", w), bus.s_HWDATA,    64'hAAAA_5555_1234_0001);
            tick();
        end
        bus.s_HREADYOUT = 1'b1;
        @(negedge HCLK);
        chk("wait_end_rdy0",  bus.m_HREADY[0], 1'b1);
        chk("wait_end_trans", bus.s_HTRANS,    HTRANS_NONSEQ);
        chk("wait_end_addr",  bus.s_HADDR,     32'h200);

        // ---------------- byte write from port 1 ----------------
        do_reset();
        bus.m_HTRANS[1] = HTRANS_NONSEQ; bus.m_HADDR[1] = 32'hD058_0000;
        bus.m_HWRITE[1] = 1'b1;          bus.m_HSIZE[1] = 3'd0;
        tick();
        bus.m_HTRANS[1] = HTRANS_IDLE;
        bus.m_HWDATA[1] = 64'hFF;
        @(negedge HCLK);
        chk("wr_trans", bus.s_HTRANS, HTRANS_NONSEQ);
        chk("wr_write", bus.s_HWRITE, 1'b1);
        chk("wr_addr",  bus.s_HADDR,  32'hD058_0000);
        chk("wr_size",  bus.s_HSIZE,  3'd0);
        tick();
        @(negedge HCLK);
        chk("wr_wdata", bus.s_HWDATA,    64'hFF);
        chk("wr_rdy1",  bus.m_HREADY[1], 1'b1);

        // ---------------- reset during data phase ----------------
        do_reset();
        bus.m_HTRANS[0] = HTRANS_NONSEQ; bus.m_HADDR[0] = 32'h500;
        tick();
        bus.m_HTRANS[0] = HTRANS_IDLE;
        tick();
        bus.s_HREADYOUT = 1'b0;
        @(negedge HCLK);
        chk("rdp_rdy0_stall", bus.m_HREADY[0], 1'b0);
        tick();
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk("rdp_mready", bus.m_HREADY, 2'b11);
        chk("rdp_strans", bus.s_HTRANS, HTRANS_IDLE);
        chk("rdp_mresp",  bus.m_HRESP,  2'b00);
        tick();
        HRESETn = 1'b1;
        bus.s_HREADYOUT = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            chk($sformatf("rdp_after%0d_trans", k), bus.s_HTRANS, HTRANS_IDLE);
            chk($sformatf("rdp_after%0d_sel", k),   bus.s_HSEL,   1'b0);
            tick();
        end

        // ---------------- randomized vs transaction model ----------------
        do_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; mr_prev[p] = 1'b1; cur_tr[p] = HTRANS_IDLE;
            s_addr[p] = '0; s_wr[p] = 1'b0; s_sz[p] = '0; s_wd[p] = '0;
        end
        own_v = 1'b0; own_p = 0; own_wd = '0; last_p = 1; n_iss = 0;

        for (int c = 0; c < 2000; c++) begin
            logic iss;
            int   w;
            for (int p = 0; p < 2; p++) begin
                if (mr_prev[p]) begin
                    cur_tr[p]       = 2'($urandom_range(0, 3));
                    bus.m_HTRANS[p] = cur_tr[p];
                    bus.m_HADDR[p]  = $urandom & 32'hFFFF_FFF8;
                    bus.m_HWRITE[p] = 1'($urandom_range(0, 1));
                    bus.m_HSIZE[p]  = 3'($urandom_range(0, 3));
                    bus.m_HPROT[p]  = 4'($urandom_range(0, 15));
                    bus.m_HBURST[p] = 3'($urandom_range(0, 7));
                end
            end
            bus.s_HREADYOUT = ($urandom_range(0, 3) != 0);
            bus.s_HRESP     = ($urandom_range(0, 7) == 0);
            bus.s_HRDATA    = {$urandom, $urandom};
            @(negedge HCLK);

            for (int p = 0; p < 2; p++) begin
                if (pend[p])                 exp_mr[p] = 1'b0;
                else if (own_v && own_p == p) exp_mr[p] = bus.s_HREADYOUT;
                else                          exp_mr[p] = 1'b1;
                chk($sformatf("rnd_mready%0d", p), bus.m_HREADY[p], exp_mr[p]);
                chk($sformatf("rnd_mresp%0d", p), bus.m_HRESP[p],
                    (own_v && own_p == p) ? bus.s_HRESP : 1'b0);
            end

            iss = bus.s_HREADYOUT && (pend[0] || pend[1]);
            if (pend[0] && pend[1]) w = 1 - last_p;
            else                    w = pend[1] ? 1 : 0;
            chk("rnd_strans", bus.s_HTRANS, iss ? HTRANS_NONSEQ : HTRANS_IDLE);
            chk("rnd_ssel",   bus.s_HSEL,   iss);
            if (iss) begin
                chk("rnd_saddr",  bus.s_HADDR,  s_addr[w]);
                chk("rnd_swrite", bus.s_HWRITE, s_wr[w]);
                chk("rnd_ssize",  bus.s_HSIZE,  s_sz[w]);
                n_iss++;
            end
            if (own_v) chk("rnd_swdata", bus.s_HWDATA, own_wd);

            // state after the coming edge
            if (own_v && bus.s_HREADYOUT) own_v = 1'b0;
            if (iss) begin
                own_v = 1'b1; own_p = w; own_wd = s_wd[w];
                last_p = w; pend[w] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                acc[p] = exp_mr[p] && cur_tr[p][1];
                if (acc[p]) begin
                    pend[p]   = 1'b1;
                    s_addr[p] = bus.m_HADDR[p];
                    s_wr[p]   = bus.m_HWRITE[p];
                    s_sz[p]   = bus.m_HSIZE[p];
                    s_wd[p]   = {$urandom, $urandom};
                end
                mr_prev[p] = exp_mr[p];
            end
            tick();
            for (int p = 0; p < 2; p++)
                if (acc[p]) bus.m_HWDATA[p] = s_wd[p];
        end
        chk("rnd_issue_activity", 64'(n_iss > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_dual_arb.md
AHB_DUAL_ARB -- requirements
Module: ahb_dual_arb

Interface
REQ-001 SHALL have parameter NM, default 2, number of AHB-lite masters; only 2 is supported.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 64, data width.
REQ-004 SHALL have port HCLK  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports m_HADDR/m_HTRANS/m_HWRITE/m_HSIZE/m_HBURST/m_HPROT/m_HWDATA  input  [NM] x AW/2/1/3/3/4/DW  master address and data-phase signals.
REQ-007 SHALL have ports m_HREADY/m_HRESP/m_HRDATA  output  [NM] x 1/1/DW  per-master ready, response and read data.
REQ-008 SHALL have ports s_HSEL/s_HADDR/s_HTRANS/s_HWRITE/s_HSIZE/s_HBURST/s_HPROT/s_HWDATA/s_HREADY  output  1/AW/2/1/3/3/4/DW/1  shared slave port.
REQ-009 SHALL have ports s_HREADYOUT/s_HRESP/s_HRDATA  input  1/1/DW  slave ready, response and read data.

Function
REQ-010 Each master port SHALL run a 3-state FSM: IDLE, PEND (address held, awaiting grant), DATA (issued, slave data phase).
REQ-011 In IDLE, m_HREADY SHALL be 1; a master presenting HTRANS[1]=1 SHALL have its address-phase signals captured into a per-port hold register, and the port SHALL move to PEND.
REQ-012 In PEND, m_HREADY SHALL be 0, so the master keeps HWDATA stable.
REQ-013 In DATA, m_HREADY SHALL equal s_HREADYOUT, and m_HRESP SHALL equal s_HRESP.
REQ-014 In DATA, when s_HREADYOUT=1 with HTRANS[1]=1, the new address SHALL be captured and the port SHALL move to PEND; otherwise the port SHALL move to IDLE.
REQ-015 m_HRDATA SHALL equal s_HRDATA for all ports; m_HRESP SHALL be 0 for any port not in DATA.
REQ-016 Issue: in a cycle with s_HREADYOUT=1 and at least one port in PEND, the arbiter SHALL drive the winner's hold register onto the slave with s_HTRANS=2'b10, s_HSEL=1 and s_HBURST=3'b000; the winner SHALL move to DATA at the edge.
REQ-017 SEQ SHALL be forwarded as NONSEQ, and BUSY SHALL be treated as IDLE.
REQ-018 Arbitration SHALL be round-robin: if both ports are in PEND, the port not issued last SHALL win; the last-issued pointer SHALL update only on issue.
REQ-019 If no port issues, or s_HREADYOUT=0, s_HTRANS SHALL be 2'b00 and s_HSEL=0; the address mux SHALL hold the last issue.
REQ-020 s_HREADY SHALL equal s_HREADYOUT.
REQ-021 s_HWDATA SHALL be muxed from the data-phase owner register, which is set on issue.
REQ-022 Invariant: at most one port SHALL be in DATA at any time, since issue coincides with completion of the current owner.
REQ-023 Latency: with no contention and a zero-wait slave, address accepted in cycle T SHALL be issued in T+1 and complete with m_HREADY=1 in T+2.

Reset
REQ-024 While HRESETn=0, all ports SHALL be in IDLE, all m_HREADY=1, m_HRESP=0, s_HTRANS=2'b00, s_HSEL=0, the last-issued pointer=1 (port 0 wins first), and hold registers=0.
REQ-025 Assertion of HRESETn mid-transfer SHALL abandon all pending and in-flight transfers with no slave access.

Structure
REQ-026 Package ahb_arb_pkg SHALL hold the port-state enum (IDLE/PEND/DATA), the HTRANS/HBURST constants and the hold-register struct.
REQ-027 Sub-module ahb_arb_port SHALL contain one port's FSM and hold register, instantiated NM times; the top level SHALL contain arbitration, the muxes and the owner register.

Verification
REQ-028 Port 0 read of 0x1000 at cycle 0 with a zero-wait slave -> s_HADDR=0x1000 with NONSEQ in cycle 1; m_HREADY[0] low in cycle 1 and high in cycle 2 with slave data.
REQ-029 Both ports NONSEQ in cycle 0 after reset -> port 0 issued in cycle 1, port 1 in cycle 2; m_HREADY[1] high in cycle 3.
REQ-030 Both ports requesting continuously -> issue order strictly 0,1,0,1 over 8 transfers.
REQ-031 Slave holds HREADYOUT low 3 cycles -> no new issue and owner m_HREADY low for 3 cycles, s_HWDATA stable.
REQ-032 Port 1 writes 0xFF to 0xD0580000 with HSIZE=0 -> slave sees HWRITE=1, HADDR=0xD0580000, HSIZE=0 and HWDATA=0xFF in the data phase.
REQ-033 HRESETn low while port 0 is in DATA -> next cycle all m_HREADY=1 and s_HTRANS=IDLE; port 0 reissues nothing.
